snn_sample_scheduler: RTL and testbench

SNN_SAMPLE_SCHEDULER -- requirements
Module: snn_sample_scheduler

---
 rtl/snn_sample_scheduler.sv | 128 ++++++++++++
 tb/tb_snn_sample_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_sample_scheduler.sv
// Sample scheduler for a spiking network: presents a latched spike pattern for
// NUM_STEPS cycles, counts output spikes per neuron, then scans for the winner.
// Optional macro SNN_SCHED_COUNT_OUT_EN adds the res_count output (winner's spike count).
module snn_sample_scheduler #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 10,
  parameter int NUM_STEPS   = 16,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_INPUTS-1:0]          in_pattern,
  output logic                           net_rst,
  output logic [NUM_INPUTS-1:0]          net_spike_in,
  input  logic [NUM_OUTPUTS-1:0]         net_spike_out,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [$clog2(NUM_OUTPUTS)-1:0] res_class,
  output logic                           res_none,
`ifdef SNN_SCHED_COUNT_OUT_EN
  output logic                           busy,
  output logic [COUNT_WIDTH-1:0]         res_count
`else
  output logic                           busy
`endif
);

  localparam int IDX_W  = $clog2(NUM_OUTPUTS);
  localparam int STEP_W = $clog2(NUM_STEPS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_SCAN,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [NUM_INPUTS-1:0]   r_pattern;
  logic [STEP_W-1:0]       r_step;
  logic [IDX_W-1:0]        r_idx;
  logic [COUNT_WIDTH-1:0]  r_count [NUM_OUTPUTS];
  logic [IDX_W-1:0]        r_best_idx;
  logic [COUNT_WIDTH-1:0]  r_best_cnt;
  logic [COUNT_WIDTH-1:0]  w_scan_cnt;
  logic                    w_done;
  logic                    w_count_en;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_CLEAR;
      S_CLEAR: w_next = S_RUN;
      S_RUN:   if (r_step == STEP_W'(NUM_STEPS - 1)) w_next = S_DRAIN;
      S_DRAIN: w_next = S_SCAN;
      S_SCAN:  if (r_idx == IDX_W'(NUM_OUTPUTS - 1)) w_next = S_DONE;
      S_DONE:  if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_scan_cnt = r_count[r_idx];
  // DRAIN still counts: the network's last response arrives one cycle after the final input step.
  assign w_count_en = (r_state == S_RUN) || (r_state == S_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pattern  <= '0;
      r_step     <= '0;
      r_idx      <= '0;
      r_best_idx <= '0;
      r_best_cnt <= '0;
      for (int k = 0; k < NUM_OUTPUTS; k++) r_count[k] <= '0;
    end else begin
      if (r_state == S_IDLE && in_valid) r_pattern <= in_pattern;
      if (r_state == S_CLEAR) begin
        r_step <= '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) r_count[k] <= '0;
      end
      if (r_state == S_RUN) r_step <= r_step + 1'b1;
      if (w_count_en) begin
        for (int k = 0; k < NUM_OUTPUTS; k++)
          if (net_spike_out[k]) r_count[k] <= sat_inc(r_count[k]);
      end
      if (r_state == S_DRAIN) begin
        r_idx      <= '0;
        r_best_idx <= '0;
        r_best_cnt <= '0;
      end
      // Strictly-greater replacement keeps the lowest index on ties.
      if (r_state == S_SCAN) begin
        r_idx <= r_idx + 1'b1;
        if (w_scan_cnt > r_best_cnt) begin
          r_best_cnt <= w_scan_cnt;
          r_best_idx <= r_idx;
        end
      end
    end
  end

  assign w_done       = (r_state == S_DONE);
  assign in_ready     = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign net_rst      = (r_state == S_CLEAR);
  assign net_spike_in = (r_state == S_RUN) ? r_pattern : '0;
  assign res_valid    = w_done;
  assign res_class    = w_done ? r_best_idx : '0;
  assign res_none     = w_done && (r_best_cnt == '0);
`ifdef SNN_SCHED_COUNT_OUT_EN
  assign res_count    = w_done ? r_best_cnt : '0;
`endif

endmodule

// File: tb/tb_snn_sample_scheduler.sv
// Bench for snn_sample_scheduler: two instances (8-bit and 4-bit counters) driven in
// lockstep, compared against a count/argmax reference model of each sample.
module tb_snn_sample_scheduler;

  localparam int NI    = 4;
  localparam int NO    = 10;
  localparam int NS    = 16;
  localparam int CW    = 8;
  localparam int CWS   = 4;
  localparam int CLS_W = $clog2(NO);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [NI-1:0]    in_pattern;
  logic [NO-1:0]    net_spike_out;
  logic             res_ready;

  logic             in_ready, net_rst, res_valid, res_none, busy;
  logic [NI-1:0]    net_spike_in;
  logic [CLS_W-1:0] res_class;
  logic             in_ready_s, net_rst_s, res_valid_s, res_none_s, busy_s;
  logic [NI-1:0]    net_spike_in_s;
  logic [CLS_W-1:0] res_class_s;
`ifdef SNN_SCHED_COUNT_OUT_EN
  logic [CW-1:0]    res_count;
  logic [CWS-1:0]   res_count_s;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [NO-1:0] g_spk [0:NS];

  always #5 clk = ~clk;

  snn_sample_scheduler #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .NUM_STEPS(NS), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pattern(in_pattern),
    .net_rst(net_rst), .net_spike_in(net_spike_in), .net_spike_out(net_spike_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class), .res_none(res_none),
`ifdef SNN_SCHED_COUNT_OUT_EN
    .busy(busy), .res_count(res_count)
`else
    .busy(busy)
`endif
  );

  snn_sample_scheduler #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .NUM_STEPS(NS), .COUNT_WIDTH(CWS)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_pattern(in_pattern),
    .net_rst(net_rst_s), .net_spike_in(net_spike_in_s), .net_spike_out(net_spike_out),
    .res_valid(res_valid_s), .res_ready(res_ready), .res_class(res_class_s), .res_none(res_none_s),
`ifdef SNN_SCHED_COUNT_OUT_EN
    .busy(busy_s), .res_count(res_count_s)
`else
    .busy(busy_s)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: total spikes per neuron over the NS+1 counted cycles, clipped to
  // the counter ceiling, then first neuron holding the maximum wins.
  task automatic model(input int cw, output int cls, output int cnt, output logic none);
    int best, c, ceil_v;
    ceil_v = (1 << cw) - 1;
    best = 0;
    cls = 0;
    for (int k = 0; k < NO; k++) begin
      c = 0;
      for (int s = 0; s <= NS; s++) c += int'(g_spk[s][k]);
      if (c > ceil_v) c = ceil_v;
      if (c > best) begin
        best = c;
        cls = k;
      end
    end
    cnt = best;
    none = (best == 0);
  endtask

  task automatic fill_zero();
    for (int s = 0; s <= NS; s++) g_spk[s] = '0;
  endtask

  task automatic fill_random();
    int dens [NO];
    for (int k = 0; k < NO; k++) dens[k] = int'($urandom_range(0, 100));
    for (int s = 0; s <= NS; s++)
      for (int k = 0; k < NO; k++)
        g_spk[s][k] = (int'($urandom_range(0, 99)) < dens[k]);
  endtask

  task automatic check_result(input int cls, input int cnt, input logic none,
                              input int cls_s, input int cnt_s, input logic none_s);
    check("res_valid", res_valid, 1);
    check("res_class", res_class, cls);
    check("res_none", res_none, none);
    check("in_ready_done", in_ready, 0);
    check("res_valid_s", res_valid_s, 1);
    check("res_class_s", res_class_s, cls_s);
    check("res_none_s", res_none_s, none_s);
`ifdef SNN_SCHED_COUNT_OUT_EN
    check("res_count", res_count, cnt);
    check("res_count_s", res_count_s, cnt_s);
`else
    if (cnt < 0 || cnt_s < 0) check("count_model", 0, 1);
`endif
  endtask

  // Entered at a falling edge while idle; returns at a falling edge back in idle.
  task automatic run_sample(input logic [NI-1:0] pat, input int hold);
    int cls, cnt, cls_s, cnt_s;
    logic none, none_s;
    model(CW, cls, cnt, none);
    model(CWS, cls_s, cnt_s, none_s);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_pattern = pat;
    @(negedge clk);
    check("net_rst_clear", net_rst, 1);
    check("busy_clear", busy, 1);
    check("spike_in_clear", net_spike_in, 0);
    in_valid = 1'($urandom);
    in_pattern = NI'($urandom);
    net_spike_out = NO'($urandom);
    for (int s = 0; s < NS; s++) begin
      @(negedge clk);
      check("spike_in_run", net_spike_in, pat);
      check("spike_in_run_s", net_spike_in_s, pat);
      check("net_rst_run", net_rst, 0);
      net_spike_out = g_spk[s];
    end
    @(negedge clk);
    check("spike_in_drain", net_spike_in, 0);
    net_spike_out = g_spk[NS];
    for (int i = 0; i < NO; i++) begin
      @(negedge clk);
      check("res_valid_scan", res_valid, 0);
      in_valid = 1'b0;
      net_spike_out = NO'($urandom);
    end
    @(negedge clk);
    check_result(cls, cnt, none, cls_s, cnt_s, none_s);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      @(negedge clk);
      check_result(cls, cnt, none, cls_s, cnt_s, none_s);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_after", res_valid, 0);
    check("busy_after", busy, 0);
    check("in_ready_after", in_ready_s, 1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_pattern = '0;
    net_spike_out = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_net_rst", net_rst, 0);
    check("rst_spike_in", net_spike_in, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_class", res_class, 0);
    check("rst_res_none", res_none, 0);
    check("rst_busy", busy, 0);
`ifdef SNN_SCHED_COUNT_OUT_EN
    check("rst_res_count", res_count, 0);
`endif
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      net_spike_out = NO'($urandom);
      res_ready = 1'($urandom);
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_in_ready", in_ready, 1);
      check("idle_res_valid", res_valid, 0);
    end
    res_ready = 1'b0;

    // Neuron 3 every counted cycle
    fill_zero();
    for (int s = 0; s <= NS; s++) g_spk[s][3] = 1'b1;
    run_sample(4'b1011, 0);

    // Neurons 2 and 7 tie at 5 spikes, 7 late (including the drain cycle)
    fill_zero();
    for (int s = 0; s < 5; s++) g_spk[s][2] = 1'b1;
    for (int s = NS - 4; s <= NS; s++) g_spk[s][7] = 1'b1;
    run_sample(4'b0110, 1);

    // Neuron 1 saturates the narrow counter
    fill_zero();
    for (int s = 0; s <= NS; s++) g_spk[s][1] = 1'b1;
    run_sample(4'b1111, 0);

    // 16 vs 17 spikes: distinct in wide counters, tie after saturation
    fill_zero();
    for (int s = 0; s < NS; s++) g_spk[s][0] = 1'b1;
    for (int s = 0; s <= NS; s++) g_spk[s][5] = 1'b1;
    run_sample(4'b0001, 2);

    // Silent network, result held 10 cycles
    fill_zero();
    run_sample(4'b1000, 10);

    // Abort mid-run at step 8
    fill_random();
    in_valid = 1'b1;
    in_pattern = 4'b0101;
    @(negedge clk);
    in_valid = 1'b0;
    for (int s = 0; s <= 8; s++) begin
      net_spike_out = g_spk[s];
      @(negedge clk);
    end
    check("abort_pre_spike_in", net_spike_in, 4'b0101);
    rst = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_spike_in", net_spike_in, 0);
    check("abort_busy", busy, 0);
    check("abort_res_valid", res_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      net_spike_out = NO'($urandom);
      @(negedge clk);
      check("abort_no_result", res_valid, 0);
      check("abort_idle", busy_s, 0);
    end

    fill_random();
    run_sample(NI'($urandom), 0);
    for (int n = 0; n < 25; n++) begin
      fill_random();
      run_sample(NI'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
